vga_scan_engine: RTL and testbench

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_scan_engine_if.sv | 28 ++
 rtl/vga_axis_counter.sv | 25 ++
 rtl/vga_scan_engine.sv | 90 +++++++++
 tb/tb_vga_scan_engine.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and colour field layout
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int RED_HI = 7;
  localparam int RED_LO = 5;
  localparam int GRN_HI = 4;
  localparam int GRN_LO = 2;
  localparam int BLU_HI = 1;
  localparam int BLU_LO = 0;

  // RRRGGGBB -> 24-bit {red, green, blue} by repeating each field's bits
  function automatic logic [23:0] expand_rgb(input logic [7:0] c);
    logic [7:0] r, g, b;
    r = {c[RED_HI:RED_LO], c[RED_HI:RED_LO], c[RED_HI:RED_HI-1]};
    g = {c[GRN_HI:GRN_LO], c[GRN_HI:GRN_LO], c[GRN_HI:GRN_HI-1]};
    b = {c[BLU_HI:BLU_LO], c[BLU_HI:BLU_LO], c[BLU_HI:BLU_LO], c[BLU_HI:BLU_LO]};
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// rtl/vga_scan_engine_if.sv - pixel request and DAC-side signal bundle
interface vga_scan_engine_if;
  import vga_pkg::*;

  logic [7:0]         color_in;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               hsync;
  logic               vsync;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;
  logic               sync;
  logic               clk;
  logic               blank;
  logic               frame_start;

  modport master (
    input  color_in,
    output next_x, next_y, hsync, vsync, red, green, blue, sync, clk, blank, frame_start
  );

  modport slave (
    output color_in,
    input  next_x, next_y, hsync, vsync, red, green, blue, sync, clk, blank, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping scan counter; wrap flags the enabled step from TOTAL-1 to 0
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             rev_reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clock or negedge rev_reset) begin
    if (!rev_reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - VGA raster timing, colour expansion and sync generation
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input logic               clock,
  input logic               rev_reset,
  vga_scan_engine_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               pix_en;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap;
  logic               active, hs, vs;
  logic [7:0]         color_q;
  logic               active_q, hs_q, vs_q, frame_q;
  logic [23:0]        rgb;

  // Pixel clock is the system clock divided by two; pix_en doubles as the DAC clock.
  always_ff @(posedge clock or negedge rev_reset) begin
    if (!rev_reset) pix_en <= 1'b0;
    else            pix_en <= ~pix_en;
  end

  vga_axis_counter #(.TOTAL(H_TOTAL), .WIDTH(COORD_W)) u_h_cnt (
    .clock(clock), .rev_reset(rev_reset), .en(pix_en), .count(h_cnt), .wrap(h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .WIDTH(COORD_W)) u_v_cnt (
    .clock(clock), .rev_reset(rev_reset), .en(h_wrap), .count(v_cnt), .wrap(v_wrap)
  );

  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  // Colour, blank and syncs share one register stage so they stay aligned at the DAC.
  always_ff @(posedge clock or negedge rev_reset) begin
    if (!rev_reset) begin
      color_q  <= '0;
      active_q <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      frame_q <= v_wrap;
      if (pix_en) begin
        color_q  <= bus.color_in;
        active_q <= active;
        hs_q     <= hs;
        vs_q     <= vs;
      end
    end
  end

  assign rgb = active_q ? expand_rgb(color_q) : 24'd0;

  assign bus.next_x      = h_cnt;
  assign bus.next_y      = v_cnt;
  assign bus.red         = rgb[23:16];
  assign bus.green       = rgb[15:8];
  assign bus.blue        = rgb[7:0];
  assign bus.blank       = active_q;
  assign bus.hsync       = ~hs_q;
  assign bus.vsync       = ~vs_q;
  assign bus.sync        = 1'b0;
  assign bus.clk         = pix_en;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb/tb_vga_scan_engine.sv - randomized scoreboard bench for vga_scan_engine on a reduced raster
module tb_vga_scan_engine;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clock = 1'b0;
  logic rev_reset;

  vga_scan_engine_if bus();

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clock(clock),
    .rev_reset(rev_reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       bl, hsn, vsn;
  } pix_t;

  pix_t   q[$];
  pix_t   exp_pix;
  int     errors = 0;
  int     checks = 0;
  int     k = 0;
  longint cyc = 0;
  longint last_fs = -1;
  int     hrun = 0;
  int     vrun = 0;
  logic [7:0] cur_c;
  bit     hit;

  // Expected DAC outputs for raster pixel number p (counted from frame origin) shown with colour c
  function automatic pix_t model(input int p, input logic [7:0] c);
    pix_t m;
    int x, y;
    bit act;
    x   = p % HT;
    y   = (p / HT) % VT;
    act = (x < HA) && (y < VA);
    m.r   = act ? {c[7:5], c[7:5], c[7:6]} : 8'd0;
    m.g   = act ? {c[4:2], c[4:2], c[4:3]} : 8'd0;
    m.b   = act ? {c[1:0], c[1:0], c[1:0], c[1:0]} : 8'd0;
    m.bl  = act;
    m.hsn = !((x >= HA + HF) && (x < HA + HF + HS));
    m.vsn = !((y >= VA + VF) && (y < VA + VF + VS));
    return m;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!rev_reset) begin
      hrun    = 0;
      vrun    = 0;
      last_fs = -1;
    end else begin
      if (!bus.clk && q.size() > 0) begin
        exp_pix = q.pop_front();
        check("red",   bus.red,   exp_pix.r);
        check("green", bus.green, exp_pix.g);
        check("blue",  bus.blue,  exp_pix.b);
        check("blank", bus.blank, exp_pix.bl);
        check("hsync", bus.hsync, exp_pix.hsn);
        check("vsync", bus.vsync, exp_pix.vsn);
      end
      if (!bus.hsync) hrun++;
      else if (hrun > 0) begin
        check("hsync_width", hrun, 2 * HS);
        hrun = 0;
      end
      if (!bus.vsync) vrun++;
      else if (vrun > 0) begin
        check("vsync_width", vrun, 2 * VS * HT);
        vrun = 0;
      end
      if (bus.frame_start) begin
        if (last_fs >= 0) check("frame_period", cyc - last_fs, 2 * FT);
        last_fs = cyc;
      end
    end
  end

  task automatic step_clock();
    @(negedge clock);
    case ($urandom_range(0, 3))
      0:       bus.color_in = 8'hFF;
      1:       bus.color_in = 8'b0001_1100;
      default: bus.color_in = 8'($urandom);
    endcase
    cur_c = bus.color_in;
    @(posedge clock);
    #1;
    k++;
    check("next_x", bus.next_x, (k / 2) % HT);
    check("next_y", bus.next_y, ((k / 2) / HT) % VT);
    check("frame_start", bus.frame_start, ((k % 2 == 0) && ((k / 2 - 1) % FT == FT - 1)) ? 1 : 0);
    if (k % 2 == 0) q.push_back(model(k / 2 - 1, cur_c));
  endtask

  task automatic check_reset_values();
    check("rst_next_x", bus.next_x, 0);
    check("rst_next_y", bus.next_y, 0);
    check("rst_hsync", bus.hsync, 1);
    check("rst_vsync", bus.vsync, 1);
    check("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
    check("rst_blank", bus.blank, 0);
    check("rst_frame_start", bus.frame_start, 0);
    check("rst_clk", bus.clk, 0);
    check("sync_tie", bus.sync, 0);
  endtask

  initial begin
    rev_reset    = 1'b0;
    bus.color_in = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();

    @(posedge clock);
    #2;
    rev_reset = 1'b1;
    k = 0;
    for (int i = 0; i < 2600; i++) step_clock();

    hit = 1'b0;
    for (int i = 0; i < 4 * FT; i++) begin
      if (bus.next_y == 10'd5 && bus.next_x == 10'd3) begin
        hit = 1'b1;
        break;
      end
      step_clock();
    end
    check("reset_trigger_reached", hit, 1);

    #3;
    rev_reset = 1'b0;
    #1;
    check_reset_values();
    q.delete();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();

    @(posedge clock);
    #2;
    rev_reset = 1'b1;
    k = 0;
    #1;
    check("post_reset_next_y", bus.next_y, 0);
    for (int i = 0; i < 2400; i++) step_clock();

    @(negedge clock);
    #1;
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
